greyscale_bayer_ds: RTL and testbench
=====================================

Name: greyscale_bayer_ds

Overview:
Parametrised successor to the camera-path greyscale converter. It takes a raw Bayer pixel stream from the capture block (iDATA, iX_Cont, iY_Cont, iDVAL), pairs each row with the previous row held in an internal line buffer, and emits one grey sample per 2x2 Bayer quad (half resolution in X and Y). It sits between CCD capture and the frame-buffer/display path. The reduction mode is selectable at runtime and only changes at frame boundaries.

Parameters:
DATA_W, 12, raw and grey pixel width
X_W, 11, width of the X/Y coordinate inputs
LINE_W, 1280, pixels per row; line-buffer depth
BAYER, 0, quad layout: 0 = GRBG (even row G1,R; odd row B,G2), 1 = RGGB

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-low reset
iX_Cont  in  X_W  column of iDATA
iY_Cont  in  X_W  row of iDATA
iDATA  in  DATA_W  raw Bayer pixel
iDVAL  in  1  iDATA valid
iMODE  in  2  00 average, 01 luma-weighted, 10 green-only, 11 max-of-quad
oGrey  out  DATA_W  grey sample
oX  out  X_W-1  quad column (iX_Cont>>1)
oY  out  X_W-1  quad row (iY_Cont>>1)
oDVAL  out  1  oGrey/oX/oY valid, one-cycle pulse per quad

Behaviour:
- Clock and reset: single clock iCLK; iRST is synchronous, active-low.
- Reset (iRST=0 at posedge): oGrey=0, oX=0, oY=0, oDVAL=0, all pipeline valids=0, row_ok=0, active mode=00. Line-buffer RAM is not cleared.
- Qualified pixel: iDVAL=1 and iX_Cont<LINE_W. Unqualified cycles are ignored, with no write, no output and no state change.
- Even row (iY_Cont[0]=0): write iDATA to linebuf[iX_Cont]. On the first qualified pixel of the row, set row_ok=1 and last_even_y=iY_Cont.
- Odd row, even X: hold iDATA in a bottom-left register.
- Odd row, odd X: forms a quad from linebuf[X-1], linebuf[X], the held bottom-left pixel and iDATA. It produces an output only if row_ok=1 and last_even_y==iY_Cont-1. Otherwise the quad is dropped silently (skipped or missing top row).
- Odd-X pixel with no preceding even-X pixel in the same row since reset: the stale bottom-left register is used. This is not a checked condition.
- Latency: the qualifying odd/odd pixel is sampled at edge k. oDVAL=1 with its data during the cycle after edge k+3.
  - Stage 1: sync RAM read plus input register.
  - Stage 2: sum/multiply.
  - Stage 3: output register.
- Pipeline behaviour: fully pipelined, one quad per cycle sustained, no backpressure. oDVAL is low in every cycle without a new result. oGrey holds its last value while oDVAL=0.
- Arithmetic (all unsigned, floor):
  - Avg: (R+G1+G2+B)>>2, with a DATA_W+2 accumulator.
  - Luma: (77*R + 75*(G1+G2) + 29*B)>>8, with a DATA_W+9 accumulator. Weights sum to 256, so the result never exceeds 2^DATA_W-1 and no saturation is needed.
  - Green: (G1+G2)>>1.
  - Max: largest of the four.
- Mode: iMODE is latched into the active mode only on a qualified pixel with iX_Cont==0 and iY_Cont==0 (frame start). That pixel uses the newly latched mode. Changes to iMODE mid-frame have no effect until the next frame start.
- Reset mid-operation: in-flight quads are discarded (no oDVAL). The next odd row after reset produces nothing until an even row has been written.

Test Plan:
- GRBG, mode 00, rows 0/1 with every quad R=400, G1=G2=800, B=200 -> 640 pulses, oGrey=550, oY=0, oX=0..639 in order.
- Same quad, frame start with iMODE=01 -> oGrey=611. iMODE=10 -> 800. iMODE=11 -> 800. All-4095 quad in luma mode -> 4095.
- Rows 0..3 at 1280 px with pattern (x^y)&12'hFFF and 20 ns gaps, mode 00 -> exactly 1280 pulses, oY 0 then 1. Each result matches the reference model, with oDVAL exactly 3 clocks after the odd/odd input.
- Row 0 applied, then row 3 (row 1/2 skipped) -> zero pulses. Then rows 4/5 -> 640 pulses.
- iMODE switched from 00 to 01 at row 1, x=600 -> all row-1 outputs stay in avg mode. Luma takes effect after the next (0,0) pixel.
- iRST=0 for one cycle mid-row 1 -> no oDVAL from pre-reset quads, all outputs 0. The remainder of row 1 produces no output. Rows 2/3 after it produce 640 valid quads.
- iDVAL toggling 1/0 every cycle within rows 0/1 -> same values as the contiguous case, 640 pulses. Pixels with iX_Cont>=1280 are ignored.

Source files
------------

// File: rtl/greyscale_bayer_ds.sv
// Bayer-quad to half-resolution grey converter: pairs each odd row with the buffered even row
// above it and reduces every 2x2 quad by a frame-latched mode (avg, luma, green, max).
module greyscale_bayer_ds #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned X_W    = 11,
  parameter int unsigned LINE_W = 1280,
  parameter int unsigned BAYER  = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [X_W-1:0]    iX_Cont,
  input  logic [X_W-1:0]    iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oGrey,
  output logic [X_W-2:0]    oX,
  output logic [X_W-2:0]    oY,
  output logic              oDVAL
);

  localparam int unsigned AW = $clog2(LINE_W);
  localparam int unsigned LW = DATA_W + 9;

  logic [DATA_W-1:0] linebuf [LINE_W];

  logic              pix_ok, frame_start, even_wr, quad_go;
  logic [1:0]        mode_now, mode_q;
  logic              row_ok_q;
  logic [X_W-1:0]    last_even_y_q;
  logic [AW-1:0]     addr, addr_l;
  logic [DATA_W-1:0] bl_q;

  // Stage 1: top pair from the line buffer plus the bottom pair
  logic              s1_vld_q;
  logic [DATA_W-1:0] top0_q, top1_q, bl1_q, br_q;
  logic [1:0]        s1_mode_q;
  logic [X_W-2:0]    s1_x_q, s1_y_q;

  // Stage 2: every reduction computed in parallel
  logic              s2_vld_q;
  logic [DATA_W-1:0] avg_q, luma_q, green_q, max_q;
  logic [1:0]        s2_mode_q;
  logic [X_W-2:0]    s2_x_q, s2_y_q;

  // Stage 3: mode selection
  logic              s3_vld_q;
  logic [DATA_W-1:0] s3_grey_q;
  logic [X_W-2:0]    s3_x_q, s3_y_q;

  logic [DATA_W-1:0] r, g1, g2, b, max_01, max_23, max_all, sel;
  logic [DATA_W+1:0] sum4;
  logic [DATA_W:0]   gsum;
  logic [LW-1:0]     luma;

  always_comb begin
    pix_ok      = iDVAL && ({1'b0, iX_Cont} < (X_W+1)'(LINE_W));
    frame_start = pix_ok && (iX_Cont == '0) && (iY_Cont == '0);
    mode_now    = frame_start ? iMODE : mode_q;
    even_wr     = pix_ok && !iY_Cont[0];
    // Drop quads whose top row was never written or belongs to a different row pair
    quad_go     = pix_ok && iY_Cont[0] && iX_Cont[0] && row_ok_q &&
                  (last_even_y_q == iY_Cont - X_W'(1));
    addr        = iX_Cont[AW-1:0];
    addr_l      = {iX_Cont[AW-1:1], 1'b0};
  end

  always_ff @(posedge iCLK) begin
    if (even_wr) linebuf[addr] <= iDATA;
    if (pix_ok && iY_Cont[0] && !iX_Cont[0]) bl_q <= iDATA;
  end

  always_comb begin
    if (BAYER == 0) begin
      g1 = top0_q;
      r  = top1_q;
      b  = bl1_q;
      g2 = br_q;
    end else begin
      r  = top0_q;
      g1 = top1_q;
      g2 = bl1_q;
      b  = br_q;
    end
    sum4    = (DATA_W+2)'(r) + (DATA_W+2)'(g1) + (DATA_W+2)'(g2) + (DATA_W+2)'(b);
    gsum    = (DATA_W+1)'(g1) + (DATA_W+1)'(g2);
    luma    = LW'(77) * LW'(r) + LW'(75) * LW'(gsum) + LW'(29) * LW'(b);
    max_01  = (r > g1) ? r : g1;
    max_23  = (g2 > b) ? g2 : b;
    max_all = (max_01 > max_23) ? max_01 : max_23;
  end

  always_comb begin
    sel = max_q;
    case (s2_mode_q)
      2'b00:   sel = avg_q;
      2'b01:   sel = luma_q;
      2'b10:   sel = green_q;
      default: sel = max_q;
    endcase
  end

  // Datapath registers carry no reset; only the valids qualify them
  always_ff @(posedge iCLK) begin
    if (quad_go) begin
      top0_q    <= linebuf[addr_l];
      top1_q    <= linebuf[addr];
      bl1_q     <= bl_q;
      br_q      <= iDATA;
      s1_mode_q <= mode_now;
      s1_x_q    <= iX_Cont[X_W-1:1];
      s1_y_q    <= iY_Cont[X_W-1:1];
    end
    if (s1_vld_q) begin
      avg_q     <= DATA_W'(sum4 >> 2);
      luma_q    <= DATA_W'(luma >> 8);
      green_q   <= DATA_W'(gsum >> 1);
      max_q     <= max_all;
      s2_mode_q <= s1_mode_q;
      s2_x_q    <= s1_x_q;
      s2_y_q    <= s1_y_q;
    end
    if (s2_vld_q) begin
      s3_grey_q <= sel;
      s3_x_q    <= s2_x_q;
      s3_y_q    <= s2_y_q;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      mode_q        <= 2'b00;
      row_ok_q      <= 1'b0;
      last_even_y_q <= '0;
      s1_vld_q      <= 1'b0;
      s2_vld_q      <= 1'b0;
      s3_vld_q      <= 1'b0;
      oGrey         <= '0;
      oX            <= '0;
      oY            <= '0;
      oDVAL         <= 1'b0;
    end else begin
      if (frame_start) mode_q <= iMODE;
      if (even_wr) begin
        row_ok_q      <= 1'b1;
        last_even_y_q <= iY_Cont;
      end
      s1_vld_q <= quad_go;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      oDVAL    <= s3_vld_q;
      if (s3_vld_q) begin
        oGrey <= s3_grey_q;
        oX    <= s3_x_q;
        oY    <= s3_y_q;
      end
    end
  end

endmodule

// File: tb/tb_greyscale_bayer_ds.sv
// Directed bench for greyscale_bayer_ds: a behavioural model pushes expected quads to a
// scoreboard as pixels are driven; a negedge monitor pops and compares each oDVAL pulse.
module tb_greyscale_bayer_ds;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [10:0] iX_Cont, iY_Cont;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic [1:0]  iMODE;
  logic [11:0] oGrey;
  logic [9:0]  oX, oY;
  logic        oDVAL;

  greyscale_bayer_ds #(
    .DATA_W (12),
    .X_W    (11),
    .LINE_W (1280),
    .BAYER  (0)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .iMODE   (iMODE),
    .oGrey   (oGrey),
    .oX      (oX),
    .oY      (oY),
    .oDVAL   (oDVAL)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int grey;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   last_grey = 0;
  bit   mon_en = 1'b0;
  logic [1:0] cur_mode = 2'b00;

  // Reference model state
  int mb [1280];
  int m_bl = 0;
  bit m_row_ok = 1'b0;
  int m_ley = 0;
  int m_mode = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_grey(int r, int g1, int g2, int b, int mode);
    int m;
    case (mode)
      0:       return (r + g1 + g2 + b) >> 2;
      1:       return (77 * r + 75 * (g1 + g2) + 29 * b) >> 8;
      2:       return (g1 + g2) >> 1;
      default: begin
        m = r;
        if (g1 > m) m = g1;
        if (g2 > m) m = g2;
        if (b > m) m = b;
        return m;
      end
    endcase
  endfunction

  // kind 0: fixed GRBG quad R=400 G=800 B=200; 1: (x^y)&FFF; 2: all 4095; 3: random
  function automatic int val(int kind, int x, int y);
    case (kind)
      0:       return (y % 2 == 0) ? ((x % 2 == 0) ? 800 : 400) : ((x % 2 == 0) ? 200 : 800);
      1:       return (x ^ y) & 'hFFF;
      2:       return 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic pix(input int x, input int y, input int d, input bit dv);
    exp_t e;
    @(posedge iCLK);
    #1;
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iDATA   = 12'(d);
    iDVAL   = dv;
    iMODE   = cur_mode;
    if (dv && x < 1280) begin
      if (x == 0 && y == 0) m_mode = int'(cur_mode);
      if (y % 2 == 0) begin
        mb[x]    = d;
        m_row_ok = 1'b1;
        m_ley    = y;
      end else if (x % 2 == 0) begin
        m_bl = d;
      end else if (m_row_ok && m_ley == y - 1) begin
        // GRBG: top row G1,R; bottom row B,G2
        e.grey = model_grey(mb[x], mb[x-1], d, m_bl, m_mode);
        e.x    = x >> 1;
        e.y    = y >> 1;
        e.cyc  = cyc + 4;
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_row(input int y, input int kind, input int x0, input int x1, input int gap);
    for (int x = x0; x <= x1; x++) begin
      pix(x, y, val(kind, x, y), 1'b1);
      repeat (gap) pix(0, 0, 0, 1'b0);
    end
  endtask

  task automatic drain();
    repeat (8) pix(0, 0, 0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge iCLK);
    #1;
    iRST  = 1'b0;
    iDVAL = 1'b0;
    @(posedge iCLK);
    #1;
    sb.delete();
    m_row_ok  = 1'b0;
    m_mode    = 0;
    last_grey = 0;
    chk("rst_grey", 32'(oGrey), 32'd0);
    chk("rst_x", 32'(oX), 32'd0);
    chk("rst_y", 32'(oY), 32'd0);
    chk("rst_dval", 32'(oDVAL), 32'd0);
    iRST = 1'b1;
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    if (mon_en && iRST) begin
      if (oDVAL) begin
        pulses++;
        if (sb.size() == 0) begin
          chk("spurious_dval", 32'(oDVAL), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("grey", 32'(oGrey), 32'(e.grey));
          chk("x", 32'(oX), 32'(e.x));
          chk("y", 32'(oY), 32'(e.y));
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
        last_grey = int'(oGrey);
      end else begin
        chk("hold", 32'(oGrey), 32'(last_grey));
      end
    end
  end

  initial begin
    iRST = 1'b0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0; iDATA = '0; iMODE = 2'b00;
    repeat (3) @(posedge iCLK);
    #1;
    chk("init_grey", 32'(oGrey), 32'd0);
    chk("init_x", 32'(oX), 32'd0);
    chk("init_y", 32'(oY), 32'd0);
    chk("init_dval", 32'(oDVAL), 32'd0);
    iRST = 1'b1;
    mon_en = 1'b1;

    // Average of the fixed quad across a full row pair
    cur_mode = 2'b00; pulses = 0;
    run_row(0, 0, 0, 1279, 0);
    run_row(1, 0, 0, 1279, 0);
    drain();
    chk("avg_pulses", 32'(pulses), 32'd640);
    chk("avg_value", 32'(last_grey), 32'd550);

    // Other modes latched at frame start
    cur_mode = 2'b01; run_row(0, 0, 0, 1279, 0); run_row(1, 0, 0, 1279, 0); drain();
    chk("luma_value", 32'(last_grey), 32'd611);
    cur_mode = 2'b10; run_row(0, 0, 0, 1279, 0); run_row(1, 0, 0, 1279, 0); drain();
    chk("green_value", 32'(last_grey), 32'd800);
    cur_mode = 2'b11; run_row(0, 0, 0, 1279, 0); run_row(1, 0, 0, 1279, 0); drain();
    chk("max_value", 32'(last_grey), 32'd800);
    cur_mode = 2'b01; run_row(0, 2, 0, 1279, 0); run_row(1, 2, 0, 1279, 0); drain();
    chk("luma_full", 32'(last_grey), 32'd4095);

    // Four rows of (x^y) with two idle cycles between pixels
    cur_mode = 2'b00; pulses = 0;
    for (int y = 0; y < 4; y++) run_row(y, 1, 0, 1279, 2);
    drain();
    chk("xor_pulses", 32'(pulses), 32'd1280);

    // Missing top row for row 3, then a proper pair
    pulses = 0;
    run_row(0, 3, 0, 1279, 0);
    run_row(3, 3, 0, 1279, 0);
    drain();
    chk("skip_pulses", 32'(pulses), 32'd0);
    run_row(4, 3, 0, 1279, 0);
    run_row(5, 3, 0, 1279, 0);
    drain();
    chk("pair45_pulses", 32'(pulses), 32'd640);

    // Mid-frame mode change must wait for the next frame start
    cur_mode = 2'b00; pulses = 0;
    run_row(0, 0, 0, 1279, 0);
    run_row(1, 0, 0, 599, 0);
    cur_mode = 2'b01;
    run_row(1, 0, 600, 1279, 0);
    drain();
    chk("midswitch_pulses", 32'(pulses), 32'd640);
    chk("midswitch_value", 32'(last_grey), 32'd550);
    run_row(0, 0, 0, 1279, 0);
    run_row(1, 0, 0, 1279, 0);
    drain();
    chk("newframe_luma", 32'(last_grey), 32'd611);

    // Reset in the middle of row 1
    cur_mode = 2'b00;
    run_row(0, 3, 0, 1279, 0);
    run_row(1, 3, 0, 599, 0);
    do_reset();
    pulses = 0;
    run_row(1, 3, 600, 1279, 0);
    drain();
    chk("post_rst_pulses", 32'(pulses), 32'd0);
    run_row(2, 3, 0, 1279, 0);
    run_row(3, 3, 0, 1279, 0);
    drain();
    chk("rows23_pulses", 32'(pulses), 32'd640);

    // Toggling iDVAL, then out-of-range columns
    pulses = 0;
    run_row(0, 0, 0, 1279, 1);
    run_row(1, 0, 0, 1279, 1);
    drain();
    chk("toggle_pulses", 32'(pulses), 32'd640);
    chk("toggle_value", 32'(last_grey), 32'd550);
    pulses = 0;
    pix(1300, 0, 7, 1'b1);
    for (int x = 1280; x < 1292; x++) pix(x, 1, 4095, 1'b1);
    drain();
    chk("oob_pulses", 32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
